// File: rtl/unpool_ctrl.sv
// unpool_ctrl: sequences per-channel pooled/history reads into the unpooling datapath
module unpool_ctrl #(
    parameter int SIZE    = 8,
    parameter int MAX_CH  = 4,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [2:0]               num_ch,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [15:0]       mem_pooled,
    input  logic signed [2:0]        mem_history,
    output logic                     unpool_start,
    output logic signed [15:0]       pooled_value,
    output logic signed [2:0]        history_value,
    input  logic                     unpool_end,
    input  logic                     out_end
);
    localparam int N = SIZE * SIZE;
    localparam int K_W = $clog2(N + 1);
    localparam int W_W = $clog2(TIMEOUT + 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);
    localparam logic [W_W-1:0] W_LAST = W_W'(TIMEOUT);
    localparam logic [2:0] MAX_C = 3'(MAX_CH);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAIT_END, NEXT_CH, FINISH} state_t;

    state_t           state, next;
    logic [2:0]       ch, nch, nch_in;
    logic [K_W-1:0]   kc;
    logic [W_W-1:0]   wc;
    logic             rd_d1, out_seen, end_seen;
    logic             accept, last_ch, ended, seen_out, go, to;

    assign accept   = (state == IDLE) && start;
    assign nch_in   = (num_ch == 3'd0) ? 3'd1 : (num_ch > MAX_C) ? MAX_C : num_ch;
    assign last_ch  = (ch == nch - 3'd1);
    assign ended    = end_seen | unpool_end;
    assign seen_out = out_seen | out_end;
    assign go       = ended & (~last_ch | seen_out);
    assign to       = (wc == W_LAST) & ~go;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        next         = state;
        busy         = (state != IDLE);
        done         = (state == FINISH);
        mem_rd_en    = (state == ISSUE);
        unpool_start = (state == ISSUE) || (state == DRAIN) || (state == WAIT_END);
        mem_addr     = mem_rd_en ? ADDR_W'(32'(ch) * 32'(N) + 32'(kc)) : '0;
        case (state)
            IDLE:     next = start ? ISSUE : IDLE;
            ISSUE:    next = (kc == K_LAST) ? DRAIN : ISSUE;
            DRAIN:    next = (kc == K_W'(1)) ? WAIT_END : DRAIN;
            WAIT_END: next = go ? (last_ch ? FINISH : NEXT_CH) : (to ? FINISH : WAIT_END);
            NEXT_CH:  next = ISSUE;
            FINISH:   next = IDLE;
            default:  next = IDLE;
        endcase
    end

    // Read data arrives one cycle after the strobe; register it so element k lands two cycles after issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_d1         <= 1'b0;
            pooled_value  <= '0;
            history_value <= '0;
        end else begin
            rd_d1         <= mem_rd_en;
            pooled_value  <= rd_d1 ? mem_pooled : '0;
            history_value <= rd_d1 ? mem_history : '0;
        end
    end

    // Element counter (ISSUE and DRAIN) and wait-cycle counter (WAIT_END)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kc <= '0;
            wc <= '0;
        end else begin
            kc <= ((state == ISSUE && kc != K_LAST) || (state == DRAIN && kc == '0)) ? kc + K_W'(1) : '0;
            wc <= (state == WAIT_END) ? wc + W_W'(1) : '0;
        end
    end

    // Job bookkeeping: channel count/index, error flag and the end/out_end captures
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch       <= '0;
            nch      <= '0;
            err      <= 1'b0;
            out_seen <= 1'b0;
            end_seen <= 1'b0;
        end else begin
            nch      <= accept ? nch_in : nch;
            ch       <= accept ? 3'd0 : (state == NEXT_CH) ? ch + 3'd1 : ch;
            err      <= accept ? 1'b0 : (state == WAIT_END && to) ? 1'b1 : err;
            out_seen <= accept ? 1'b0 : (unpool_start && last_ch && out_end) ? 1'b1 : out_seen;
            end_seen <= (state == WAIT_END) && (next == WAIT_END) && ended;
        end
    end
endmodule

// File: tb/tb_unpool_ctrl.sv
// tb_unpool_ctrl: directed scoreboard bench for unpool_ctrl
module tb_unpool_ctrl;
    logic        clk = 1'b0;
    logic        reset_n, start, unpool_end, out_end;
    logic [2:0]  num_ch;
    logic        busy, done, err, mem_rd_en, unpool_start;
    logic [9:0]  mem_addr;
    logic [15:0] mem_pooled = '0;
    logic [2:0]  mem_history = '0;
    logic [15:0] pooled_value;
    logic [2:0]  history_value;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          addr_q[$];
    logic [9:0]  last_addr = '0;
    bit          pv0 = 0, pv1 = 0;
    logic [9:0]  pa0 = '0, pa1 = '0;

    unpool_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_ch(num_ch),
        .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_pooled(mem_pooled), .mem_history(mem_history),
        .unpool_start(unpool_start), .pooled_value(pooled_value),
        .history_value(history_value), .unpool_end(unpool_end), .out_end(out_end)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pool_f(input logic [9:0] a);
        return 16'(a * 16'd1237) ^ 16'hA5A5;
    endfunction

    function automatic logic [2:0] hist_f(input logic [9:0] a);
        return {1'b0, a[1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory: data valid one cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_pooled  <= pool_f(mem_addr);
            mem_history <= hist_f(mem_addr);
        end
    end

    // Scoreboard: addresses popped as issued, data expected two cycles after issue
    always @(negedge clk) begin
        if (!reset_n) begin
            pv0 = 0;
            pv1 = 0;
        end
        chk("pooled", {16'd0, pooled_value}, pv1 ? {16'd0, pool_f(pa1)} : 32'd0);
        chk("history", {29'd0, history_value}, pv1 ? {29'd0, hist_f(pa1)} : 32'd0);
        pv1 = pv0;
        pa1 = pa0;
        pv0 = mem_rd_en;
        pa0 = mem_addr;
        if (mem_rd_en) begin
            if (addr_q.size() == 0) chk("extra_rd", {22'd0, mem_addr}, 32'hFFFF_FFFF);
            else chk("addr", {22'd0, mem_addr}, addr_q.pop_front());
            last_addr = mem_addr;
        end
        if (done) done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_addrs(input int nch);
        for (int c = 0; c < nch; c++)
            for (int k = 0; k < 64; k++) addr_q.push_back((c * 64 + k) & 1023);
    endtask

    task automatic run_job(input string tag, input logic [2:0] n_in, input int exp_ch,
                           input bit out_early, input bit noise);
        int n;
        int d0;
        d0 = done_cnt;
        push_addrs(exp_ch);
        num_ch = n_in;
        start = 1'b1;
        for (int c = 0; c < exp_ch; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_rd_first"}, mem_rd_en, 1);
            if (!mem_rd_en) return;
            chk({tag, "_ustart"}, unpool_start, 1);
            chk({tag, "_busy"}, busy, 1);
            if (c == 0) chk({tag, "_err0"}, err, 0);
            n = 0;
            while (mem_rd_en && n < 100) begin
                n++;
                if (noise && n == 10) begin start = 1'b1; unpool_end = 1'b1; end
                if (noise && n == 11) begin start = 1'b0; unpool_end = 1'b0; end
                if (out_early && c == exp_ch - 1 && n == 20) out_end = 1'b1;
                if (out_early && c == exp_ch - 1 && n == 21) out_end = 1'b0;
                @(negedge clk);
            end
            chk({tag, "_len"}, n, 64);
            chk({tag, "_drain_us"}, unpool_start, 1);
            repeat (2) @(negedge clk);
            chk({tag, "_wait_rd"}, mem_rd_en, 0);
            repeat (4) @(negedge clk);
            unpool_end = 1'b1;
            out_end = (c == exp_ch - 1) && !out_early;
            @(negedge clk);
            unpool_end = 1'b0;
            out_end = 1'b0;
            chk({tag, "_us_low"}, unpool_start, 0);
            chk({tag, "_done"}, done, (c == exp_ch - 1) ? 1 : 0);
            if (c == exp_ch - 1) chk({tag, "_err"}, err, 0);
        end
        @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_q_empty"}, addr_q.size(), 0);
    endtask

    initial begin
        int n;
        int d0;
        reset_n = 1'b1;
        start = 1'b0;
        num_ch = 3'd0;
        unpool_end = 1'b0;
        out_end = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd", mem_rd_en, 0);
        chk("rst_addr", {22'd0, mem_addr}, 0);
        chk("rst_us", unpool_start, 0);
        chk("rst_pool", {16'd0, pooled_value}, 0);
        chk("rst_hist", {29'd0, history_value}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_job("one", 3'd1, 1, 0, 0);
        run_job("three", 3'd3, 3, 1, 0);
        run_job("zero", 3'd0, 1, 0, 0);
        run_job("seven", 3'd7, 4, 0, 0);
        chk("seven_last_addr", {22'd0, last_addr}, 255);
        run_job("noise", 3'd2, 2, 0, 1);

        d0 = done_cnt;
        push_addrs(1);
        num_ch = 3'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("to_rd", mem_rd_en, 1);
        n = 0;
        while (mem_rd_en && n < 100) begin n++; @(negedge clk); end
        chk("to_len", n, 64);
        repeat (2) @(negedge clk);
        chk("to_wait_us", unpool_start, 1);
        n = 0;
        while (!done && n < 1100) begin @(negedge clk); n++; end
        chk("to_cycles", n, 1024);
        chk("to_err", err, 1);
        @(negedge clk);
        chk("to_idle", busy, 0);
        chk("to_err_held", err, 1);
        chk("to_done_once", done_cnt - d0, 1);
        chk("to_q_empty", addr_q.size(), 0);
        run_job("after_to", 3'd1, 1, 0, 0);

        d0 = done_cnt;
        push_addrs(2);
        num_ch = 3'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (mem_rd_en && n < 100) begin n++; @(negedge clk); end
        chk("rst_job_len", n, 64);
        repeat (6) @(negedge clk);
        unpool_end = 1'b1;
        @(negedge clk);
        unpool_end = 1'b0;
        @(negedge clk);
        chk("rst_ch1_rd", mem_rd_en, 1);
        chk("rst_ch1_addr", {22'd0, mem_addr}, 64);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_rd", mem_rd_en, 0);
        chk("mid_addr", {22'd0, mem_addr}, 0);
        chk("mid_us", unpool_start, 0);
        chk("mid_pool", {16'd0, pooled_value}, 0);
        addr_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_idle", busy, 0);
        chk("mid_nodone", done_cnt - d0, 0);
        run_job("after_rst", 3'd1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
